// File: rtl/wb_ram_responder.sv
// Wishbone responder for the 16-bit inner bus backed by a register-file RAM.
// It serves single accesses and 4- or 8-beat bursts. Burst beats wrap at the
// end of the RAM. Addresses outside the decode window end with a one-cycle error.
module wb_ram_responder #(
   parameter int unsigned ADDR_W           = 24,
   parameter int unsigned DATA_W           = 16,
   parameter int unsigned DEPTH_LOG2       = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_adr,
   input  logic [DATA_W-1:0] wb_i_dat,
   input  logic [1:0]        wb_sel,
   input  logic              wb_4_burst,
   input  logic              wb_8_burst,
   output logic [DATA_W-1:0] wb_o_dat,
   output logic              wb_ack,
   output logic              wb_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 3;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        beat_cnt;
   logic [CNT_W-1:0]        last_beat;
   logic [DEPTH_LOG2-1:0]   base_idx;
   logic                    we_r;

   logic [DATA_W-1:0]       ram [DEPTH];

   logic                    accept_c;
   logic                    hit_c;
   logic [CNT_W-1:0]        n_last_c;
   logic                    acc_en_c;
   logic                    acc_we_c;
   logic [DEPTH_LOG2-1:0]   acc_idx_c;
   logic [DATA_W-1:0]       acc_rdata_c;

   // The request is accepted in IDLE only. Holding off while ack or err is high
   // keeps a request that is still driven in its ack cycle from being served twice.
   assign accept_c    = (state == IDLE) && wb_cyc && wb_stb && !wb_ack && !wb_err;
   assign hit_c       = (wb_adr[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);
   assign n_last_c    = wb_8_burst ? CNT_W'(7) : (wb_4_burst ? CNT_W'(3) : CNT_W'(0));
   assign acc_rdata_c = ram[acc_idx_c];

   // Select the RAM access for this cycle: the first beat comes from the bus, later beats from the burst state
   always_comb begin
      acc_en_c  = 1'b0;
      acc_we_c  = wb_we;
      acc_idx_c = wb_adr[DEPTH_LOG2-1:0];
      if (state == IDLE) begin
         acc_en_c = accept_c && hit_c;
      end else begin
         acc_en_c  = wb_cyc;
         acc_we_c  = we_r;
         acc_idx_c = base_idx + DEPTH_LOG2'(beat_cnt);
      end
   end

   // Byte-lane writes. The RAM is never cleared, and a reset cycle blocks the write.
   always_ff @(posedge i_clk) begin
      if (!i_rst && acc_en_c && acc_we_c) begin
         if (wb_sel[0]) ram[acc_idx_c][7:0]  <= wb_i_dat[7:0];
         if (wb_sel[1]) ram[acc_idx_c][15:8] <= wb_i_dat[15:8];
      end
   end

   // Control FSM with registered ack, err and read data
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         last_beat <= '0;
         base_idx  <= '0;
         we_r      <= 1'b0;
         wb_ack    <= 1'b0;
         wb_err    <= 1'b0;
         wb_o_dat  <= '0;
      end else begin
         wb_ack <= 1'b0;
         wb_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if (!hit_c) begin
                     wb_err <= 1'b1;
                  end else begin
                     wb_ack <= 1'b1;
                     if (!wb_we) wb_o_dat <= acc_rdata_c;
                     if (n_last_c != '0) begin
                        state     <= BURST;
                        beat_cnt  <= CNT_W'(1);
                        last_beat <= n_last_c;
                        base_idx  <= wb_adr[DEPTH_LOG2-1:0];
                        we_r      <= wb_we;
                     end
                  end
               end
            end
            BURST: begin
               if (!wb_cyc) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
               end else begin
                  wb_ack <= 1'b1;
                  if (!we_r) wb_o_dat <= acc_rdata_c;
                  if (beat_cnt == last_beat) begin
                     state    <= IDLE;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: single accesses, byte lanes, wrapping and
// 8-beat bursts, burst hints, decode miss, abort, reset mid-burst, and back-to-back requests.
module tb_wb_ram_responder;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        wb_cyc, wb_stb, wb_we;
   logic [23:0] wb_adr;
   logic [15:0] wb_i_dat;
   logic [1:0]  wb_sel;
   logic        wb_4_burst, wb_8_burst;
   logic [15:0] wb_o_dat;
   logic        wb_ack, wb_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] wr_buf [8];
   logic [15:0] rd_buf [8];

   wb_ram_responder dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_adr     (wb_adr),
      .wb_i_dat   (wb_i_dat),
      .wb_sel     (wb_sel),
      .wb_4_burst (wb_4_burst),
      .wb_8_burst (wb_8_burst),
      .wb_o_dat   (wb_o_dat),
      .wb_ack     (wb_ack),
      .wb_err     (wb_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic bus_idle();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
      wb_i_dat = '0; wb_sel = 2'b00; wb_4_burst = 1'b0; wb_8_burst = 1'b0;
   endtask

   // Drive one request. Strobe is held for the accept cycle only, and data advances on each ack.
   task automatic run_burst(input logic we, input logic [23:0] adr, input logic [1:0] sel,
                            input logic h4, input logic h8,
                            output int acks, output int first, output int last,
                            output int errs, output int efirst);
      acks = 0; first = -1; last = -1; errs = 0; efirst = -1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel;
      wb_4_burst = h4; wb_8_burst = h8; wb_i_dat = wr_buf[0];
      for (int i = 1; i <= 12; i++) begin
         tick();
         wb_stb = 1'b0;
         if (wb_err) begin
            errs++;
            if (efirst < 0) efirst = i;
         end
         if (wb_ack) begin
            if (acks < 8) rd_buf[acks] = wb_o_dat;
            acks++;
            if (first < 0) first = i;
            last = i;
            if (acks < 8) wb_i_dat = wr_buf[acks];
         end
      end
      bus_idle();
      tick();
   endtask

   task automatic do_write(input logic [23:0] adr, input logic [15:0] dat, input logic [1:0] sel);
      int a, f, l, e, ef;
      wr_buf[0] = dat;
      run_burst(1'b1, adr, sel, 1'b0, 1'b0, a, f, l, e, ef);
   endtask

   task automatic do_read(input logic [23:0] adr, output logic [15:0] dat);
      int a, f, l, e, ef;
      run_burst(1'b0, adr, 2'b11, 1'b0, 1'b0, a, f, l, e, ef);
      dat = rd_buf[0];
   endtask

   task automatic test_reset();
      bus_idle();
      i_rst = 1'b1;
      tick(); tick(); tick();
      n_checks++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb_ack); end
      n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", wb_err); end
      n_checks++; if (wb_o_dat !== 16'h0000) begin n_fail++; $display("FAIL reset_dat: got %h want 0000", wb_o_dat); end
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int a, f, l, e, ef;
      wr_buf[0] = 16'hBEEF;
      run_burst(1'b1, 24'h000010, 2'b11, 1'b0, 1'b0, a, f, l, e, ef);
      n_checks++; if (a !== 1) begin n_fail++; $display("FAIL single_wr_acks: got %0d want 1", a); end
      n_checks++; if (f !== 1) begin n_fail++; $display("FAIL single_wr_latency: got %0d want 1", f); end
      run_burst(1'b0, 24'h000010, 2'b11, 1'b0, 1'b0, a, f, l, e, ef);
      n_checks++; if (a !== 1) begin n_fail++; $display("FAIL single_rd_acks: got %0d want 1", a); end
      n_checks++; if (f !== 1) begin n_fail++; $display("FAIL single_rd_latency: got %0d want 1", f); end
      n_checks++; if (rd_buf[0] !== 16'hBEEF) begin n_fail++; $display("FAIL single_rd_data: got %h want BEEF", rd_buf[0]); end
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL single_rd_err: got %0d want 0", e); end
   endtask

   task automatic test_byte_lanes();
      logic [15:0] d;
      do_write(24'h000030, 16'h1234, 2'b11);
      do_write(24'h000030, 16'hAB00, 2'b10);
      do_read(24'h000030, d);
      n_checks++; if (d !== 16'hAB34) begin n_fail++; $display("FAIL lanes_upper: got %h want AB34", d); end
      do_write(24'h000030, 16'hFFFF, 2'b00);
      do_read(24'h000030, d);
      n_checks++; if (d !== 16'hAB34) begin n_fail++; $display("FAIL lanes_none: got %h want AB34", d); end
      do_write(24'h000030, 16'h00CD, 2'b01);
      do_read(24'h000030, d);
      n_checks++; if (d !== 16'hABCD) begin n_fail++; $display("FAIL lanes_lower: got %h want ABCD", d); end
   endtask

   task automatic test_burst4_wrap();
      int a, f, l, e, ef;
      do_write(24'h0000FE, 16'h0001, 2'b11);
      do_write(24'h0000FF, 16'h0002, 2'b11);
      do_write(24'h000000, 16'h0003, 2'b11);
      do_write(24'h000001, 16'h0004, 2'b11);
      run_burst(1'b0, 24'h0000FE, 2'b11, 1'b1, 1'b0, a, f, l, e, ef);
      n_checks++; if (a !== 4) begin n_fail++; $display("FAIL b4_acks: got %0d want 4", a); end
      n_checks++; if (f !== 1 || l !== 4) begin n_fail++; $display("FAIL b4_window: got %0d..%0d want 1..4", f, l); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rd_buf[k] !== 16'(k + 1)) begin n_fail++; $display("FAIL b4_data%0d: got %h want %h", k, rd_buf[k], 16'(k + 1)); end
      end
   endtask

   task automatic test_burst8();
      int a, f, l, e, ef;
      logic [15:0] d;
      do_write(24'h000028, 16'h5555, 2'b11);
      for (int k = 0; k < 8; k++) wr_buf[k] = 16'hA0 + 16'(k);
      run_burst(1'b1, 24'h000020, 2'b11, 1'b0, 1'b1, a, f, l, e, ef);
      n_checks++; if (a !== 8) begin n_fail++; $display("FAIL b8_wr_acks: got %0d want 8", a); end
      n_checks++; if (f !== 1 || l !== 8) begin n_fail++; $display("FAIL b8_wr_window: got %0d..%0d want 1..8", f, l); end
      run_burst(1'b0, 24'h000020, 2'b11, 1'b0, 1'b1, a, f, l, e, ef);
      n_checks++; if (a !== 8) begin n_fail++; $display("FAIL b8_rd_acks: got %0d want 8", a); end
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (rd_buf[k] !== 16'hA0 + 16'(k)) begin n_fail++; $display("FAIL b8_data%0d: got %h want %h", k, rd_buf[k], 16'hA0 + 16'(k)); end
      end
      do_read(24'h000028, d);
      n_checks++; if (d !== 16'h5555) begin n_fail++; $display("FAIL b8_overrun: got %h want 5555", d); end
   endtask

   task automatic test_both_hints();
      int a, f, l, e, ef;
      run_burst(1'b0, 24'h000020, 2'b11, 1'b1, 1'b1, a, f, l, e, ef);
      n_checks++; if (a !== 8) begin n_fail++; $display("FAIL hints_acks: got %0d want 8", a); end
      n_checks++; if (rd_buf[7] !== 16'h00A7) begin n_fail++; $display("FAIL hints_last: got %h want 00A7", rd_buf[7]); end
   endtask

   task automatic test_miss();
      int a, f, l, e, ef;
      logic [15:0] d;
      do_write(24'h000000, 16'h7777, 2'b11);
      wr_buf[0] = 16'hDEAD;
      run_burst(1'b1, 24'h000100, 2'b11, 1'b0, 1'b0, a, f, l, e, ef);
      n_checks++; if (e !== 1) begin n_fail++; $display("FAIL miss_err_cycles: got %0d want 1", e); end
      n_checks++; if (ef !== 1) begin n_fail++; $display("FAIL miss_err_latency: got %0d want 1", ef); end
      n_checks++; if (a !== 0) begin n_fail++; $display("FAIL miss_acks: got %0d want 0", a); end
      do_read(24'h000000, d);
      n_checks++; if (d !== 16'h7777) begin n_fail++; $display("FAIL miss_ram: got %h want 7777", d); end
      run_burst(1'b0, 24'h800040, 2'b11, 1'b1, 1'b0, a, f, l, e, ef);
      n_checks++; if (e !== 1 || a !== 0) begin n_fail++; $display("FAIL miss_burst: got err=%0d ack=%0d want 1/0", e, a); end
   endtask

   // Drop cyc during the second ack cycle. No further ack or write should occur.
   task automatic test_abort();
      int a;
      logic [15:0] d;
      for (int k = 0; k < 4; k++) do_write(24'h000040 + 24'(k), 16'h0000, 2'b11);
      a = 0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 24'h000040; wb_sel = 2'b11;
      wb_4_burst = 1'b1; wb_i_dat = 16'h0011;
      tick(); wb_stb = 1'b0;
      if (wb_ack) a++;
      wb_i_dat = 16'h0022;
      tick();
      if (wb_ack) a++;
      wb_i_dat = 16'h0033;
      wb_cyc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wb_ack) a++;
      end
      bus_idle();
      n_checks++; if (a !== 2) begin n_fail++; $display("FAIL abort_acks: got %0d want 2", a); end
      do_read(24'h000040, d);
      n_checks++; if (d !== 16'h0011) begin n_fail++; $display("FAIL abort_w0: got %h want 0011", d); end
      do_read(24'h000041, d);
      n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL abort_w1: got %h want 0022", d); end
      do_read(24'h000042, d);
      n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL abort_w2: got %h want 0000", d); end
      do_read(24'h000043, d);
      n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL abort_w3: got %h want 0000", d); end
   endtask

   // Reset during an 8-beat read. After reset a fresh request must still be served.
   task automatic test_reset_mid();
      int a;
      logic [15:0] d;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 24'h000020; wb_sel = 2'b11;
      wb_8_burst = 1'b1;
      tick(); wb_stb = 1'b0;
      n_checks++; if (wb_ack !== 1'b1) begin n_fail++; $display("FAIL rst_mid_beat0: got %b want 1", wb_ack); end
      i_rst = 1'b1;
      tick();
      n_checks++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0", wb_ack); end
      n_checks++; if (wb_o_dat !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_dat: got %h want 0000", wb_o_dat); end
      i_rst = 1'b0;
      a = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wb_ack) a++;
      end
      n_checks++; if (a !== 0) begin n_fail++; $display("FAIL rst_mid_stray_acks: got %0d want 0", a); end
      bus_idle();
      tick();
      do_read(24'h000023, d);
      n_checks++; if (d !== 16'h00A3) begin n_fail++; $display("FAIL rst_mid_fresh: got %h want 00A3", d); end
   endtask

   // A read request held continuously is served every other cycle.
   task automatic test_back_to_back();
      logic exp_ack;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 24'h000010; wb_sel = 2'b11;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_ack = (i % 2) == 1;
         n_checks++;
         if (wb_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack%0d: got %b want %b", i, wb_ack, exp_ack); end
         if (exp_ack) begin
            n_checks++;
            if (wb_o_dat !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_dat%0d: got %h want BEEF", i, wb_o_dat); end
         end
      end
      bus_idle();
      tick(); tick();
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin wr_buf[k] = '0; rd_buf[k] = '0; end
      i_rst = 1'b1;
      bus_idle();
      test_reset();
      test_single();
      test_byte_lanes();
      test_burst4_wrap();
      test_burst8();
      test_both_hints();
      test_miss();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
